adder32_slice: RTL and testbench

- 3-bit arithmetic slice of the partitioned 32-bit adder: adds two 3-bit operands plus carry-in and produces a 4-bit result (carry-out and 3 sum bits).
- Operands arrive packed on a 7-bit input bus. Results are registered with one-cycle latency and a valid flag.
- Also exports group generate/propagate flags so an upstream carry-lookahead stage can chain slices into the full 32-bit adder.

---
 rtl/adder32_slice.sv | 61 ++++++
 tb/tb_adder32_slice.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/adder32_slice.sv
// 3-bit registered ripple-add slice of the partitioned 32-bit adder.
// Ports: clk, rst_n, in_valid, pi{a,b,cin}; po{cout,sum}, out_valid, grp_g, grp_p.
module adder32_slice (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [6:0] pi,
  output logic [3:0] po,
  output logic       out_valid,
  output logic       grp_g,
  output logic       grp_p
);

  logic [2:0] a;
  logic [2:0] b;
  logic [2:0] g;
  logic [2:0] p;
  logic [2:0] s;
  logic [3:0] c;
  logic       nxt_g;
  logic       nxt_p;

  assign a    = pi[6:4];
  assign b    = pi[3:1];
  assign c[0] = pi[0];

  for (genvar i = 0; i < 3; i++) begin : g_fa
    assign g[i]   = a[i] & b[i];
    assign p[i]   = a[i] ^ b[i];
    assign s[i]   = p[i] ^ c[i];
    assign c[i+1] = g[i] | (c[i] & p[i]);
  end

  // Lookahead view of the same bits, so cout == grp_g | grp_p & cin.
  assign nxt_g = g[2]
               | (p[2] & g[1])
               | (p[2] & p[1] & g[0]);
  assign nxt_p = &p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
    end
  end

  // Result registers only load on a valid beat; otherwise they hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      po    <= 4'b0000;
      grp_g <= 1'b0;
      grp_p <= 1'b0;
    end else if (in_valid) begin
      po    <= {c[3], s};
      grp_g <= nxt_g;
      grp_p <= nxt_p;
    end
  end

endmodule

// File: tb/tb_adder32_slice.sv
// Directed self-checking bench for adder32_slice.
// Covers reset, directed values, full sweep, hold and mid-stream reset.
module tb_adder32_slice;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [6:0] pi;
  logic [3:0] po;
  logic       out_valid;
  logic       grp_g;
  logic       grp_p;

  int checks;
  int failures;

  adder32_slice dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .pi       (pi),
    .po       (po),
    .out_valid(out_valid),
    .grp_g    (grp_g),
    .grp_p    (grp_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [3:0] obs,
                     input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag,
                         input logic [3:0] e_po,
                         input logic e_v,
                         input logic e_g,
                         input logic e_p);
    chk({tag, ".po"}, po, e_po);
    chk({tag, ".vld"}, {3'b0, out_valid}, {3'b0, e_v});
    chk({tag, ".g"}, {3'b0, grp_g}, {3'b0, e_g});
    chk({tag, ".p"}, {3'b0, grp_p}, {3'b0, e_p});
  endtask

  logic [2:0] ma;
  logic [2:0] mb;
  logic       mc;
  logic [3:0] m_po;
  logic       m_g;
  logic       m_p;

  task automatic model(input logic [6:0] v);
    logic [3:0] ab;
    ma   = v[6:4];
    mb   = v[3:1];
    mc   = v[0];
    ab   = {1'b0, ma} + {1'b0, mb};
    m_po = ab + {3'b0, mc};
    m_g  = ab > 4'd7;
    m_p  = (ma ^ mb) == 3'b111;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b1;
    in_valid = 1'b1;
    pi       = 7'b1111111;

    #2 rst_n = 1'b0;
    #1;
    chk_all("rst_async", 4'b0000, 1'b0, 1'b0, 1'b0);
    step();
    step();
    chk_all("rst_hold", 4'b0000, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    pi = 7'b0000000; step();
    chk_all("d_zero", 4'b0000, 1'b1, 1'b0, 1'b0);
    pi = 7'b0000001; step();
    chk_all("d_cin", 4'b0001, 1'b1, 1'b0, 1'b0);
    pi = 7'b1000000; step();
    chk_all("d_a4", 4'b0100, 1'b1, 1'b0, 1'b0);
    pi = 7'b0001110; step();
    chk_all("d_b7", 4'b0111, 1'b1, 1'b0, 1'b1);
    pi = 7'b1111111; step();
    chk_all("d_max", 4'b1111, 1'b1, 1'b1, 1'b0);
    pi = 7'b1010101; step();
    chk_all("d_prop", 4'b1000, 1'b1, 1'b0, 1'b1);

    for (int i = 0; i < 128; i++) begin
      pi = 7'(i);
      model(pi);
      step();
      chk_all($sformatf("sw%0d", i), m_po, 1'b1, m_g, m_p);
      chk($sformatf("inv%0d", i),
          {3'b0, po[3]},
          {3'b0, grp_g | (grp_p & mc)});
      if (i == 64) begin
        #2 rst_n = 1'b0;
        #1;
        chk_all("mid_rst", 4'b0000, 1'b0, 1'b0, 1'b0);
        #1 rst_n = 1'b1;
        #1;
        chk_all("mid_rel", 4'b0000, 1'b0, 1'b0, 1'b0);
      end
    end

    pi = 7'b0110100; step();
    chk_all("h_load", 4'b0101, 1'b1, 1'b0, 1'b0);
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      pi = 7'($urandom_range(0, 127));
      step();
      chk_all($sformatf("hold%0d", k),
              4'b0101, 1'b0, 1'b0, 1'b0);
    end

    pi       = 7'b1111111;
    in_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk_all("r2_clr", 4'b0000, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    #1 rst_n = 1'b1;
    step();
    chk_all("r2_idle", 4'b0000, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
